// File: rtl/wsn_node_pkg.sv
// Shared node-memory definitions: read FSM states, default word addresses and flag bit indices.
package wsn_node_pkg;

  localparam int unsigned WORD_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 11;
  localparam logic [10:0] FLAG_ADDR_DEF   = 11'h001;
  localparam logic [10:0] ENERGY_ADDR_DEF = 11'h002;
  localparam int unsigned ROLE_BIT_DEF = 7;
  localparam int unsigned AGG_BIT_DEF  = 6;
  localparam int unsigned RD_LAT_MAX   = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_FLAG,
    ST_WAIT_FLAG,
    ST_RD_EN,
    ST_WAIT_EN,
    ST_DECIDE,
    ST_WRITE,
    ST_DONE,
    ST_HOLD
  } node_rd_state_e;

endpackage

// File: rtl/ch_role_eval_if.sv
// Controller/memory-side bundle of the cluster-head role evaluator.
interface ch_role_eval_if
  import wsn_node_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  en;
  logic                  start;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] energy_thresh;
  logic [ADDR_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  forAggregation;
  logic                  busy;
  logic                  done;

  modport slave (
    input  en, start, data_in, energy_thresh,
    output address, wr_en, data_out, forAggregation, busy, done
  );

  modport master (
    output en, start, data_in, energy_thresh,
    input  address, wr_en, data_out, forAggregation, busy, done
  );
endinterface

// File: rtl/mem_rd_wait.sv
// Read-latency down-counter: rd_valid marks the last cycle of an RD_LAT-cycle read window.
module mem_rd_wait
  import wsn_node_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic active,
  output logic rd_valid
);
  localparam int unsigned   CNT_W    = $clog2(RD_LAT_MAX);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  logic [CNT_W-1:0] cnt;

  // Reloaded whenever no read is in flight, so back-to-back windows each see a full count.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= CNT_INIT;
    end else if (!active) begin
      cnt <= CNT_INIT;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign rd_valid = active && (cnt == '0);

endmodule

// File: rtl/ch_role_eval.sv
// Cluster-head role evaluator: reads the flag word, decides aggregation, writes the flag back.
// Define CH_ROLE_EVAL_ENERGY_GATE_EN to add the residual-energy read and low-energy demotion.
module ch_role_eval
  import wsn_node_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH  = WORD_WIDTH_DEF,
  parameter int unsigned           ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] FLAG_ADDR   = ADDR_WIDTH'(FLAG_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] ENERGY_ADDR = ADDR_WIDTH'(ENERGY_ADDR_DEF),
  parameter int unsigned           ROLE_BIT    = ROLE_BIT_DEF,
  parameter int unsigned           AGG_BIT     = AGG_BIT_DEF,
  parameter int unsigned           RD_LAT      = 1
) (
  input logic           clk,
  input logic           nrst,
  ch_role_eval_if.slave bus
);
  localparam logic [WORD_WIDTH-1:0] ROLE_MASK = WORD_WIDTH'(1) << ROLE_BIT;
  localparam logic [WORD_WIDTH-1:0] AGG_MASK  = WORD_WIDTH'(1) << AGG_BIT;

  node_rd_state_e        state, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] flag_q, flag_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  fa_q, fa_d;
  logic                  rd_active;
  logic                  rd_valid;
  logic                  energy_ok;
  logic                  in_op;

`ifdef CH_ROLE_EVAL_ENERGY_GATE_EN
  logic [WORD_WIDTH-1:0] energy_q, energy_d;
  assign energy_ok = (energy_q >= bus.energy_thresh);
`else
  assign energy_ok = 1'b1;
`endif

  assign rd_active = (state == ST_RD_FLAG) || (state == ST_WAIT_FLAG) || (state == ST_WAIT_EN);
  assign in_op     = (state != ST_IDLE) && (state != ST_HOLD);

  mem_rd_wait #(.RD_LAT(RD_LAT)) u_rd_wait (
    .clk      (clk),
    .nrst     (nrst),
    .active   (rd_active),
    .rd_valid (rd_valid)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      flag_q  <= '0;
      wdata_q <= '0;
      fa_q    <= 1'b0;
`ifdef CH_ROLE_EVAL_ENERGY_GATE_EN
      energy_q <= '0;
`endif
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      flag_q  <= flag_d;
      wdata_q <= wdata_d;
      fa_q    <= fa_d;
`ifdef CH_ROLE_EVAL_ENERGY_GATE_EN
      energy_q <= energy_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    flag_d  = flag_q;
    wdata_d = wdata_q;
    fa_d    = fa_q;
`ifdef CH_ROLE_EVAL_ENERGY_GATE_EN
    energy_d = energy_q;
`endif
    unique case (state)
      ST_IDLE: begin
        if (bus.en && bus.start) begin
          state_d = ST_RD_FLAG;
          addr_d  = FLAG_ADDR;
          fa_d    = 1'b0;
        end
      end
      ST_RD_FLAG, ST_WAIT_FLAG: begin
        if (rd_valid) begin
          flag_d = bus.data_in;
`ifdef CH_ROLE_EVAL_ENERGY_GATE_EN
          state_d = ST_RD_EN;
`else
          state_d = ST_DECIDE;
`endif
        end else begin
          state_d = ST_WAIT_FLAG;
        end
      end
`ifdef CH_ROLE_EVAL_ENERGY_GATE_EN
      ST_RD_EN: begin
        addr_d  = ENERGY_ADDR;
        state_d = ST_WAIT_EN;
      end
      ST_WAIT_EN: begin
        if (rd_valid) begin
          energy_d = bus.data_in;
          state_d  = ST_DECIDE;
        end
      end
`endif
      ST_DECIDE: begin
        if (flag_q[ROLE_BIT]) begin
          fa_d    = energy_ok;
          addr_d  = FLAG_ADDR;
          wdata_d = energy_ok ? (flag_q | AGG_MASK) : (flag_q & ~(ROLE_MASK | AGG_MASK));
          state_d = ST_WRITE;
        end else begin
          fa_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_HOLD;
      ST_HOLD: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_op && !bus.en) begin
      state_d = ST_IDLE;
      fa_d    = 1'b0;
    end
  end

  // Strobe is masked by en and nrst so an abort or reset on this edge never commits a write.
  assign bus.wr_en          = (state == ST_WRITE) && bus.en && nrst;
  assign bus.data_out       = bus.wr_en ? wdata_q : '0;
  assign bus.address        = addr_q;
  assign bus.forAggregation = fa_q;
  assign bus.busy           = in_op;
  assign bus.done           = ((state == ST_DONE) || (state == ST_HOLD)) && bus.en;

endmodule
